// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner consumer stage.
package keypad_pkg;

  localparam int KEY_W = 4;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } idx_t;

  // Bit position of a one-hot nibble; valid is low for zero or multi-hot input.
  function automatic idx_t onehot4_to_idx(input logic [3:0] v);
    idx_t r;
    r.valid = 1'b1;
    r.idx   = 2'd0;
    case (v)
      4'b0001: r.idx = 2'd0;
      4'b0010: r.idx = 2'd1;
      4'b0100: r.idx = 2'd2;
      4'b1000: r.idx = 2'd3;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keypad_row_decoder_sync2.sv
// Two-flop synchronizer for asynchronous inputs, async active-low reset.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;

  // Metastability filter chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= '0;
      q      <= '0;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/keypad_row_decoder.sv
// Keypad row decoder: samples rows per scanned column, debounces press/release,
// freezes the ring counter while a key is down and reports the key code.
module keypad_row_decoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       col_sel,
  input  logic [3:0]       rows,
  output logic             scan_enable,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       rows_s;
  state_t           state_r, state_s;
  logic [DW-1:0]    dwell_r, dwell_s;
  logic [BW-1:0]    deb_r, deb_s;
  logic [1:0]       row_r, row_s;
  logic [1:0]       col_r, col_s;
  logic [3:0]       colsel_r, colsel_s;
  logic [KEY_W-1:0] key_code_r, key_code_s;
  logic             key_valid_r, key_valid_s;
  logic             key_held_r, key_held_s;
  logic             scan_enable_r, scan_enable_s;
  idx_t             row_info_s, col_info_s;
  logic             row_hit_s, col_same_s;

  sync2 #(.WIDTH(ROWS)) u_rows_sync (
    .clk  (clk),
    .rst_n(reset),
    .d    (rows),
    .q    (rows_s)
  );

  assign scan_enable = scan_enable_r;
  assign key_code    = key_code_r;
  assign key_valid   = key_valid_r;
  assign key_held    = key_held_r;

  // Next-state and output decode; ghosted (multi-row) samples fall through to a column advance.
  always_comb begin
    row_info_s    = onehot4_to_idx(rows_s);
    col_info_s    = onehot4_to_idx(col_sel);
    row_hit_s     = rows_s[row_r];
    col_same_s    = (col_sel == colsel_r);
    state_s       = state_r;
    dwell_s       = dwell_r;
    deb_s         = deb_r;
    row_s         = row_r;
    col_s         = col_r;
    colsel_s      = colsel_r;
    key_code_s    = key_code_r;
    key_held_s    = key_held_r;
    key_valid_s   = 1'b0;
    scan_enable_s = 1'b0;
    case (state_r)
      SCAN: begin
        if (dwell_r == DWELL_LAST) begin
          dwell_s = '0;
          if (row_info_s.valid && col_info_s.valid) begin
            row_s    = row_info_s.idx;
            col_s    = col_info_s.idx;
            colsel_s = col_sel;
            deb_s    = '0;
            state_s  = DEBOUNCE;
          end else begin
            scan_enable_s = 1'b1;
          end
        end else begin
          dwell_s = dwell_r + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (row_hit_s && col_same_s) begin
          if (deb_r == DEB_LAST) begin
            key_code_s  = {row_r, col_r};
            key_valid_s = 1'b1;
            key_held_s  = 1'b1;
            state_s     = HELD;
          end else begin
            deb_s = deb_r + 1'b1;
          end
        end else begin
          dwell_s = '0;
          state_s = SCAN;
        end
      end
      HELD: begin
        if (!row_hit_s) begin
          deb_s   = '0;
          state_s = RELEASE;
        end else begin
          state_s = HELD;
        end
      end
      RELEASE: begin
        if (!row_hit_s) begin
          if (deb_r == DEB_LAST) begin
            key_held_s = 1'b0;
            dwell_s    = '0;
            state_s    = SCAN;
          end else begin
            deb_s = deb_r + 1'b1;
          end
        end else begin
          state_s = HELD;
        end
      end
      default: begin
        dwell_s    = '0;
        deb_s      = '0;
        key_held_s = 1'b0;
        state_s    = SCAN;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= SCAN;
      dwell_r       <= '0;
      deb_r         <= '0;
      row_r         <= 2'd0;
      col_r         <= 2'd0;
      colsel_r      <= 4'd0;
      key_code_r    <= 4'h0;
      key_valid_r   <= 1'b0;
      key_held_r    <= 1'b0;
      scan_enable_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      dwell_r       <= dwell_s;
      deb_r         <= deb_s;
      row_r         <= row_s;
      col_r         <= col_s;
      colsel_r      <= colsel_s;
      key_code_r    <= key_code_s;
      key_valid_r   <= key_valid_s;
      key_held_r    <= key_held_s;
      scan_enable_r <= scan_enable_s;
    end
  end

endmodule
